// File: rtl/traffic_ctrl_p.sv
// Parametrised two-direction traffic-light controller with all-red clearance,
// pedestrian walk insertion and optional night flashing (TRAFFIC_NIGHT_EN).
module traffic_ctrl_p #(
    parameter int CNT_W    = 6,
    parameter int T_GREEN1 = 30,
    parameter int T_GREEN2 = 40,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 1,
    parameter int T_WALK   = 8,
    parameter int PED_CUT  = 5,
    parameter int SHOW_TH  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             ped_req,
    input  logic             night,
    output logic             r1,
    output logic             y1,
    output logic             g1,
    output logic             r2,
    output logic             y2,
    output logic             g2,
    output logic             ped_walk,
    output logic             led_en,
    output logic [CNT_W-1:0] led_data
);

    typedef enum logic [2:0] {
        S_G1, S_Y1, S_AR1, S_G2, S_Y2, S_AR2, S_FLASH
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             ped_pend, pend_n;
    logic             walk_act, walk_n;
    logic             flash, flash_n;

    state_t           succ, target;
    logic             enter;
    logic             night_go;

    function automatic logic [CNT_W-1:0] load_of(input state_t s);
        load_of = '0;
        case (s)
            S_G1:         load_of = CNT_W'(T_GREEN1 - 1);
            S_G2:         load_of = CNT_W'(T_GREEN2 - 1);
            S_Y1, S_Y2:   load_of = CNT_W'(T_YELLOW - 1);
            S_AR1, S_AR2: load_of = CNT_W'(T_ALLRED - 1);
            default:      load_of = '0;
        endcase
    endfunction

`ifdef TRAFFIC_NIGHT_EN
    assign night_go = tick & night;
`else
    logic night_unused;
    assign night_unused = night;
    assign night_go     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_AR2;
            cnt      <= CNT_W'(T_ALLRED - 1);
            ped_pend <= 1'b0;
            walk_act <= 1'b0;
            flash    <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            ped_pend <= pend_n;
            walk_act <= walk_n;
            flash    <= flash_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pend_n  = ped_pend | ped_req;
        walk_n  = walk_act;
        flash_n = flash;
        enter   = 1'b0;

        case (state)
            S_G1:    succ = S_Y1;
            S_Y1:    succ = S_AR1;
            S_AR1:   succ = S_G2;
            S_G2:    succ = S_Y2;
            S_Y2:    succ = S_AR2;
            S_AR2:   succ = S_G1;
            default: succ = S_AR2;
        endcase
        target = succ;

        if (tick) begin
            if (night_go) begin
                walk_n = 1'b0;
                if (state == S_FLASH) begin
                    flash_n = ~flash;
                end else begin
                    state_n = S_FLASH;
                    cnt_n   = '0;
                    flash_n = 1'b0;
                end
            end else if (state == S_FLASH) begin
                enter  = 1'b1;
                target = S_AR2;
            end else if (cnt == '0) begin
                enter = 1'b1;
            end else if ((state == S_G1 || state == S_G2) && ped_pend &&
                         (int'(cnt) > PED_CUT)) begin
                cnt_n = CNT_W'(PED_CUT);
            end else begin
                cnt_n = cnt - 1'b1;
            end
        end

        // A pending request turns the next all-red into a walk; a request in
        // this same cycle stays pending for the following all-red.
        if (enter) begin
            state_n = target;
            cnt_n   = load_of(target);
            walk_n  = 1'b0;
            flash_n = 1'b0;
            if ((target == S_AR1 || target == S_AR2) && ped_pend) begin
                cnt_n  = CNT_W'(T_WALK - 1);
                walk_n = 1'b1;
                pend_n = ped_req;
            end
        end
    end

    always_comb begin
        r1       = 1'b0;
        y1       = 1'b0;
        g1       = 1'b0;
        r2       = 1'b0;
        y2       = 1'b0;
        g2       = 1'b0;
        ped_walk = walk_act;
        led_en   = 1'b0;
        led_data = cnt;
        case (state)
            S_G1: begin
                g1     = 1'b1;
                r2     = 1'b1;
                led_en = (int'(cnt) < SHOW_TH);
            end
            S_Y1: begin
                y1 = 1'b1;
                r2 = 1'b1;
            end
            S_G2: begin
                r1     = 1'b1;
                g2     = 1'b1;
                led_en = (int'(cnt) < SHOW_TH);
            end
            S_Y2: begin
                r1 = 1'b1;
                y2 = 1'b1;
            end
            S_AR1, S_AR2: begin
                r1 = 1'b1;
                r2 = 1'b1;
            end
            default: begin
                y1       = flash;
                y2       = flash;
                ped_walk = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_ctrl_p.sv
// Directed bench for traffic_ctrl_p: reset, full cycle, tick gating,
// pedestrian walks, reset mid-walk and (with TRAFFIC_NIGHT_EN) flashing.
module tb_traffic_ctrl_p;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       ped_req;
    logic       night;
    logic       r1, y1, g1, r2, y2, g2;
    logic       ped_walk;
    logic       led_en;
    logic [5:0] led_data;
    logic [5:0] lamps;

    int checks;
    int failures;
    int tick_div;
    int tick_phase;

    localparam logic [5:0] L_G1 = 6'b001_100;
    localparam logic [5:0] L_Y1 = 6'b010_100;
    localparam logic [5:0] L_G2 = 6'b100_001;
    localparam logic [5:0] L_Y2 = 6'b100_010;
    localparam logic [5:0] L_AR = 6'b100_100;

    traffic_ctrl_p dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .ped_req  (ped_req),
        .night    (night),
        .r1       (r1),
        .y1       (y1),
        .g1       (g1),
        .r2       (r2),
        .y2       (y2),
        .g2       (g2),
        .ped_walk (ped_walk),
        .led_en   (led_en),
        .led_data (led_data)
    );

    assign lamps = {r1, y1, g1, r2, y2, g2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic p, input logic n);
        rst     = r;
        ped_req = p;
        night   = n;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        tick       = (tick_phase == 0);
        tick_phase = (tick_phase + 1) % tick_div;
        @(posedge clk);
        #1;
    endtask

    task automatic measurePhase(input logic [5:0] pattern, output int n);
        n = 0;
        while (lamps === pattern && n < 500) begin
            stepCycle();
            n++;
        end
    endtask

    task automatic waitFor(input logic [5:0] pattern, input int max_cycles,
                           output logic found);
        int n;
        n = 0;
        while (lamps !== pattern && n < max_cycles) begin
            stepCycle();
            n++;
        end
        found = (lamps === pattern);
    endtask

    initial begin
        int   n;
        int   bad;
        int   cnt_g1, cnt_y1, cnt_ar, cnt_g2, cnt_y2;
        int   exp_cnt;
        logic t_pre;
        logic found;

        checks     = 0;
        failures   = 0;
        tick_div   = 1;
        tick_phase = 0;
        tick       = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);

        // Reset values with tick held high
        stepCycle();
        stepCycle();
        checkOutput("reset_lamps", lamps, L_AR);
        checkOutput("reset_led_data", led_data, 0);
        checkOutput("reset_led_en", led_en, 0);
        checkOutput("reset_walk", ped_walk, 0);

        applyStimulus(1'b0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("g1_entry_lamps", lamps, L_G1);
        checkOutput("g1_entry_cnt", led_data, 29);
        checkOutput("g1_entry_led_en", led_en, 0);
        for (int i = 0; i < 19; i++) stepCycle();
        checkOutput("led_en_at_10", led_en, 0);
        stepCycle();
        checkOutput("led_en_at_9", led_en, 1);
        checkOutput("led_data_9", led_data, 9);

        // One full 78-cycle period starting from G1 with cnt=9
        bad = 0; cnt_g1 = 0; cnt_y1 = 0; cnt_ar = 0; cnt_g2 = 0; cnt_y2 = 0;
        for (int i = 0; i < 78; i++) begin
            stepCycle();
            case (lamps)
                L_G1: cnt_g1++;
                L_Y1: cnt_y1++;
                L_AR: cnt_ar++;
                L_G2: cnt_g2++;
                L_Y2: cnt_y2++;
                default: bad++;
            endcase
        end
        checkOutput("cycle_g1_len", cnt_g1, 30);
        checkOutput("cycle_y1_len", cnt_y1, 3);
        checkOutput("cycle_ar_len", cnt_ar, 2);
        checkOutput("cycle_g2_len", cnt_g2, 40);
        checkOutput("cycle_y2_len", cnt_y2, 3);
        checkOutput("cycle_bad_lamps", bad, 0);
        checkOutput("cycle_wrap_cnt", led_data, 9);

        // Tick every 4th cycle: count holds between ticks
        tick_div   = 4;
        tick_phase = 0;
        exp_cnt    = 9;
        bad        = 0;
        for (int i = 0; i < 36; i++) begin
            t_pre = (tick_phase == 0);
            stepCycle();
            if (t_pre && exp_cnt > 0) exp_cnt--;
            if (led_data !== 6'(exp_cnt) || lamps !== L_G1) bad++;
        end
        checkOutput("gated_cnt_hold", bad, 0);
        stepCycle();
        measurePhase(L_Y1, n);
        checkOutput("gated_y1_len", n, 12);
        measurePhase(L_AR, n);
        checkOutput("gated_ar1_len", n, 4);
        measurePhase(L_G2, n);
        checkOutput("gated_g2_len", n, 160);
        measurePhase(L_Y2, n);
        checkOutput("gated_y2_len", n, 12);
        measurePhase(L_AR, n);
        checkOutput("gated_ar2_len", n, 4);
        checkOutput("gated_g1_lamps", lamps, L_G1);
        checkOutput("gated_g1_cnt", led_data, 29);

        // Pedestrian request during G2 at cnt=20
        tick_div   = 1;
        tick_phase = 0;
        n = 0;
        while (!(lamps === L_G2 && led_data === 6'd20) && n < 200) begin
            stepCycle();
            n++;
        end
        checkOutput("ped_g2_reached", (lamps === L_G2 && led_data === 6'd20), 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ped_g2_cnt19", led_data, 19);
        stepCycle();
        checkOutput("ped_g2_cut", led_data, 5);
        measurePhase(L_G2, n);
        checkOutput("ped_g2_rest_len", n, 6);
        measurePhase(L_Y2, n);
        checkOutput("ped_y2_len", n, 3);
        checkOutput("ped_ar2_walk", ped_walk, 1);
        checkOutput("ped_ar2_cnt", led_data, 7);
        checkOutput("ped_ar2_led_en", led_en, 0);
        measurePhase(L_AR, n);
        checkOutput("ped_ar2_len", n, 8);
        checkOutput("ped_after_lamps", lamps, L_G1);
        checkOutput("ped_after_walk", ped_walk, 0);
        checkOutput("ped_after_cnt", led_data, 29);

        // Request in Y1, walk in AR1, then reset mid-walk with a new request
        waitFor(L_Y1, 100, found);
        checkOutput("y1_reached", found, 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitFor(L_AR, 10, found);
        checkOutput("ar1_reached", found, 1);
        checkOutput("ar1_walk", ped_walk, 1);
        checkOutput("ar1_walk_cnt", led_data, 7);
        applyStimulus(1'b0, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        stepCycle();
        stepCycle();
        checkOutput("ar1_mid_walk", ped_walk, 1);
        checkOutput("ar1_mid_cnt", led_data, 4);
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepCycle();
        checkOutput("rst_walk_lamps", lamps, L_AR);
        checkOutput("rst_walk_walk", ped_walk, 0);
        checkOutput("rst_walk_cnt", led_data, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("rst_walk_g1", lamps, L_G1);
        waitFor(L_AR, 100, found);
        checkOutput("ar1_after_rst_reached", found, 1);
        checkOutput("ar1_pend_discarded", ped_walk, 0);
        checkOutput("ar1_after_rst_cnt", led_data, 0);

`ifdef TRAFFIC_NIGHT_EN
        // Night flashing from G2 and recovery through AR2
        stepCycle();
        checkOutput("night_g2", lamps, L_G2);
        applyStimulus(1'b0, 1'b0, 1'b1);
        stepCycle();
        checkOutput("flash_off0", lamps, 6'b000_000);
        checkOutput("flash_cnt", led_data, 0);
        checkOutput("flash_led_en", led_en, 0);
        stepCycle();
        checkOutput("flash_on", lamps, 6'b010_010);
        stepCycle();
        checkOutput("flash_off1", lamps, 6'b000_000);
        applyStimulus(1'b0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("night_exit_ar2", lamps, L_AR);
        checkOutput("night_exit_cnt", led_data, 0);
        checkOutput("night_exit_walk", ped_walk, 0);
        stepCycle();
        checkOutput("night_exit_g1", lamps, L_G1);
        checkOutput("night_exit_g1_cnt", led_data, 29);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
